// File: rtl/excp_commit.sv
// Exception commit: reports the MEM-stage exception to CP0, then sequences the
// pipeline flush and the fetch redirect to the CP0-supplied target.
module excp_commit #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_in_delayslot,
  input  logic [31:0] mem_addr,
  input  logic [7:0]  mem_excp,
  output logic [31:0] exception_type_o,
  output logic [31:0] pc_o,
  output logic        in_delayslot_o,
  output logic [31:0] mem_bad_vaddr_o,
  input  logic        exception_i,
  input  logic [31:0] return_pc_i,
  output logic        flush,
  output logic        busy,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic [15:0] excp_count
);

  localparam int unsigned PC_W    = 32;
  localparam int unsigned TYPE_W  = 32;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned COUNT_W = 16;

  // CP0 exception vector bit positions (bit 0 is the interrupt, never set here)
  localparam int unsigned EXCEP_ADELI = 1;
  localparam int unsigned EXCEP_ADELD = 2;
  localparam int unsigned EXCEP_ADES  = 3;
  localparam int unsigned EXCEP_SYS   = 4;
  localparam int unsigned EXCEP_BP    = 5;
  localparam int unsigned EXCEP_RI    = 6;
  localparam int unsigned EXCEP_OV    = 7;
  localparam int unsigned EXCEP_ERET  = 8;

  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  state_t             r_state,          w_state_nxt;
  logic [CNT_W-1:0]   r_flush_cnt,      w_flush_cnt_nxt;
  logic [PC_W-1:0]    r_redirect_pc,    w_redirect_pc_nxt;
  logic [COUNT_W-1:0] r_excp_count,     w_excp_count_nxt;
  logic               r_flush,          w_flush_nxt;
  logic               r_busy,           w_busy_nxt;
  logic               r_redirect_valid, w_redirect_valid_nxt;
  logic [TYPE_W-1:0]  w_excp_type;

  // Single highest-priority exception, only for a real instruction while idle
  always_comb begin
    w_excp_type = '0;
    if (r_state == ST_IDLE && mem_valid) begin
      if      (mem_excp[0]) w_excp_type[EXCEP_ADELI] = 1'b1;
      else if (mem_excp[1]) w_excp_type[EXCEP_ADELD] = 1'b1;
      else if (mem_excp[2]) w_excp_type[EXCEP_ADES]  = 1'b1;
      else if (mem_excp[3]) w_excp_type[EXCEP_SYS]   = 1'b1;
      else if (mem_excp[4]) w_excp_type[EXCEP_BP]    = 1'b1;
      else if (mem_excp[5]) w_excp_type[EXCEP_RI]    = 1'b1;
      else if (mem_excp[6]) w_excp_type[EXCEP_OV]    = 1'b1;
      else if (mem_excp[7]) w_excp_type[EXCEP_ERET]  = 1'b1;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt          = r_state;
    w_flush_cnt_nxt      = r_flush_cnt;
    w_redirect_pc_nxt    = r_redirect_pc;
    w_excp_count_nxt     = r_excp_count;
    w_flush_nxt          = 1'b0;
    w_busy_nxt           = 1'b0;
    w_redirect_valid_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (exception_i) begin
          w_state_nxt       = ST_FLUSH;
          w_flush_cnt_nxt   = CNT_W'(FLUSH_CYCLES - 1);
          w_redirect_pc_nxt = return_pc_i;
          w_flush_nxt       = 1'b1;
          w_busy_nxt        = 1'b1;
          if (r_excp_count != COUNT_MAX)
            w_excp_count_nxt = r_excp_count + COUNT_W'(1);
        end
      end
      ST_FLUSH: begin
        w_busy_nxt = 1'b1;
        if (r_flush_cnt == '0) begin
          w_state_nxt          = ST_REDIRECT;
          w_redirect_valid_nxt = 1'b1;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt - CNT_W'(1);
          w_flush_nxt     = 1'b1;
        end
      end
      ST_REDIRECT: begin
        if (redirect_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_redirect_valid_nxt = 1'b1;
          w_busy_nxt           = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= ST_IDLE;
      r_flush_cnt      <= '0;
      r_redirect_pc    <= '0;
      r_excp_count     <= '0;
      r_flush          <= 1'b0;
      r_busy           <= 1'b0;
      r_redirect_valid <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_flush_cnt      <= w_flush_cnt_nxt;
      r_redirect_pc    <= w_redirect_pc_nxt;
      r_excp_count     <= w_excp_count_nxt;
      r_flush          <= w_flush_nxt;
      r_busy           <= w_busy_nxt;
      r_redirect_valid <= w_redirect_valid_nxt;
    end
  end

  assign exception_type_o = w_excp_type;
  assign pc_o             = mem_pc;
  assign in_delayslot_o   = mem_in_delayslot;
  assign mem_bad_vaddr_o  = mem_addr;
  assign flush            = r_flush;
  assign busy             = r_busy;
  assign redirect_valid   = r_redirect_valid;
  assign redirect_pc      = r_redirect_pc;
  assign excp_count       = r_excp_count;

endmodule

// File: tb/tb_excp_commit.sv
// Randomized bench for excp_commit: driver pushes expected redirects into a
// scoreboard queue, an independent monitor pops them on each handshake.
module tb_excp_commit;

  localparam int unsigned FC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_pc = '0;
  logic        mem_in_delayslot = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [7:0]  mem_excp = '0;
  logic [31:0] exception_type_o;
  logic [31:0] pc_o;
  logic        in_delayslot_o;
  logic [31:0] mem_bad_vaddr_o;
  logic        exception_i = 1'b0;
  logic [31:0] return_pc_i = '0;
  logic        flush;
  logic        busy;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready = 1'b0;
  logic [15:0] excp_count;

  excp_commit #(.FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_in_delayslot(mem_in_delayslot),
    .mem_addr(mem_addr), .mem_excp(mem_excp),
    .exception_type_o(exception_type_o), .pc_o(pc_o),
    .in_delayslot_o(in_delayslot_o), .mem_bad_vaddr_o(mem_bad_vaddr_o),
    .exception_i(exception_i), .return_pc_i(return_pc_i),
    .flush(flush), .busy(busy),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .excp_count(excp_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    int          waitc;
    logic [15:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic [15:0] model_cnt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the lowest-numbered set mem_excp bit wins, reported one position up
  function automatic logic [31:0] exp_type(input logic v, input logic [7:0] e);
    if (!v) return 32'h0;
    for (int i = 0; i < 8; i++)
      if (e[i]) return 32'h1 << (i + 1);
    return 32'h0;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  task automatic rand_mem();
    mem_valid        = 1'($urandom);
    mem_pc           = $urandom;
    mem_in_delayslot = 1'($urandom);
    mem_addr         = $urandom;
    mem_excp         = 8'($urandom);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    rand_mem();
    if ($urandom_range(0, 3) == 0) mem_excp = 8'h0;
    exception_i    = 1'b0;
    redirect_ready = 1'($urandom);
    @(negedge clk);
    chk("type_idle", exception_type_o, exp_type(mem_valid, mem_excp));
    chk("pc_copy", pc_o, mem_pc);
    chk("ds_copy", 32'(in_delayslot_o), 32'(mem_in_delayslot));
    chk("vaddr_copy", mem_bad_vaddr_o, mem_addr);
    chk("idle_outs", {29'h0, flush, busy, redirect_valid}, 32'h0);
    chk("idle_count", 32'(excp_count), 32'(model_cnt));
  endtask

  // abort: 0 = complete, 1 = reset mid-flush, 2 = reset mid-redirect
  task automatic run_excp(input logic v, input logic [7:0] e, input logic [31:0] rpc,
                          input int waitc, input int abort);
    @(posedge clk); #1;
    rand_mem();
    mem_valid      = v;
    mem_excp       = e;
    exception_i    = 1'b1;
    return_pc_i    = rpc;
    redirect_ready = 1'($urandom);
    @(negedge clk);
    chk("type_accept", exception_type_o, exp_type(v, e));
    model_cnt = sat_inc(model_cnt);
    exp_q.push_back('{pc: rpc, waitc: waitc, cnt: model_cnt});
    for (int k = 0; k < FC; k++) begin
      @(posedge clk); #1;
      if (abort == 1 && k == 1) break;
      rand_mem();
      exception_i    = 1'($urandom);
      return_pc_i    = $urandom;
      redirect_ready = 1'($urandom);
      @(negedge clk);
      chk("type_busy", exception_type_o, 32'h0);
      chk("flush_busy", {30'h0, flush, busy}, 32'h3);
      chk("count_hold", 32'(excp_count), 32'(model_cnt));
    end
    if (abort == 0 || abort == 2) begin
      for (int w = 0; w < waitc; w++) begin
        @(posedge clk); #1;
        rand_mem();
        exception_i    = 1'($urandom);
        return_pc_i    = $urandom;
        redirect_ready = 1'b0;
        @(negedge clk);
        chk("redir_outs", {29'h0, flush, busy, redirect_valid}, 32'h3);
        chk("type_redir", exception_type_o, 32'h0);
        if (abort == 2 && w == 1) break;
      end
      if (abort == 0) begin
        @(posedge clk); #1;
        exception_i    = 1'($urandom);
        redirect_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        exception_i    = 1'b0;
        redirect_ready = 1'b0;
        @(negedge clk);
        chk("after_hs", {29'h0, flush, busy, redirect_valid}, 32'h0);
        return;
      end
      @(posedge clk); #1;
    end
    // Reset abandons the operation: nothing is redirected, counter clears
    rst            = 1'b1;
    exception_i    = 1'b0;
    redirect_ready = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst       = 1'b0;
    mem_valid = 1'b0;
    mem_excp  = 8'hFF;
    void'(exp_q.pop_back());
    model_cnt = '0;
    @(negedge clk);
    chk("rst_outs", {29'h0, flush, busy, redirect_valid}, 32'h0);
    chk("rst_count", 32'(excp_count), 32'h0);
    chk("rst_pc", redirect_pc, 32'h0);
    chk("rst_type", exception_type_o, 32'h0);
  endtask

  // Monitor: scores every completed redirect against the queued expectation
  initial begin
    int          flush_run = 0;
    int          wait_run = 0;
    logic        prev_v = 1'b0;
    logic [31:0] prev_pc = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        flush_run = 0;
        wait_run  = 0;
        prev_v    = 1'b0;
      end else begin
        if (flush) flush_run++;
        if (redirect_valid) begin
          if (prev_v) chk("pc_stable", redirect_pc, prev_pc);
          if (redirect_ready) begin
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_redirect actual=%h required=none", redirect_pc);
            end else begin
              e = exp_q.pop_front();
              chk("redirect_pc", redirect_pc, e.pc);
              chk("flush_len", 32'(flush_run), 32'(FC));
              chk("wait_len", 32'(wait_run), 32'(e.waitc));
              chk("hs_count", 32'(excp_count), 32'(e.cnt));
            end
            flush_run = 0;
            wait_run  = 0;
            prev_v    = 1'b0;
          end else begin
            wait_run++;
            prev_v  = 1'b1;
            prev_pc = redirect_pc;
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outs", {29'h0, flush, busy, redirect_valid}, 32'h0);
    chk("reset_count", 32'(excp_count), 32'h0);
    chk("reset_pc", redirect_pc, 32'h0);
    chk("reset_type", exception_type_o, 32'h0);

    repeat (20) idle_cycle();
    run_excp(1'b1, 8'b1000_0101, 32'hBFC0_0380, 0, 0);
    chk("count_one", 32'(excp_count), 32'h1);
    run_excp(1'b1, 8'($urandom), $urandom, 5, 0);
    run_excp(1'b0, 8'h00, 32'hBFC0_0380, 1, 0);
    run_excp(1'b1, 8'h80, 32'h8000_1234, 2, 0);
    for (int i = 0; i < 30; i++) begin
      run_excp(1'($urandom), 8'($urandom), $urandom, int'($urandom_range(0, 4)), 0);
      repeat (int'($urandom_range(0, 2))) idle_cycle();
    end
    run_excp(1'b1, 8'h08, 32'h1234_5678, 0, 1);
    run_excp(1'b1, 8'h20, 32'h2222_0000, 3, 2);
    repeat (3) idle_cycle();

    // Saturation: preload the counter near its ceiling
    @(posedge clk); #1;
    force dut.r_excp_count = 16'hFFFE;
    @(posedge clk); #1;
    release dut.r_excp_count;
    model_cnt = 16'hFFFE;
    idle_cycle();
    for (int i = 0; i < 3; i++) run_excp(1'b1, 8'($urandom), $urandom, 1, 0);
    chk("sat_count", 32'(excp_count), 32'h0000_FFFF);
    repeat (3) idle_cycle();

    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
